// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 BCM scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  // Channel positions inside a packed {B,G,R} pixel and on the rgb pins
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Packed pixel width: three channels of `bits` each
  function automatic int pix_w(input int bits);
    return 3 * bits;
  endfunction

  // Index width for a counter over n values; never narrower than one bit
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_bcm_oe.sv
// BCM display timer: holds oe low for the brightness-scaled share of a plane's slot.
// Latency: oe reacts on the cycle after start; done pulses on the final slot cycle.
// Backpressure: none; start must only be issued while no slot is running.
module hub75_bcm_oe
  import hub75_pkg::*;
#(
  parameter int BITS       = 4,
  parameter int BASE_TICKS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [col_w(BITS)-1:0]   plane,
  input  logic [7:0]               bright,
  output logic                     oe,
  output logic                     done
);

  // Wide enough to hold the longest slot length itself
  localparam int LEN_W = $clog2(BASE_TICKS << (BITS - 1)) + 1;

  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] thr_c;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] thr_q;
  logic [LEN_W-1:0] t;
  logic             active;

  // Slot length and lit length; the product keeps all bits before the >>8
  assign len_c = LEN_W'(BASE_TICKS) << plane;
  assign thr_c = LEN_W'(({8'd0, len_c} * {{LEN_W{1'b0}}, bright}) >> 8);
  assign done  = active && (t == len_q - LEN_W'(1));

  // Slot timer; oe is registered so it is low exactly while t < thr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      t      <= '0;
      len_q  <= '0;
      thr_q  <= '0;
      oe     <= 1'b1;
    end else if (start) begin
      active <= 1'b1;
      t      <= '0;
      len_q  <= len_c;
      thr_q  <= thr_c;
      oe     <= (thr_c == '0);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
        oe     <= 1'b1;
      end else begin
        t  <= t + LEN_W'(1);
        oe <= !((t + LEN_W'(1)) < thr_q);
      end
    end
  end

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 1/N scan driver: shift a row plane, latch it, then show it for a BCM-weighted slot.
// Latency: framebuffer read issued at phase 0, serial data out at phase 2 of each column.
// Backpressure: none; framebuffer must answer every read on the following cycle.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ADDR_W     = 4,
  parameter int BITS       = 4,
  parameter int CLK_DIV    = 4,
  parameter int BASE_TICKS = 64,
  parameter int LAT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               bright,
  output logic                     pix_rd,
  output logic [ADDR_W-1:0]        pix_row,
  output logic [col_w(COLS)-1:0]   pix_col,
  input  logic [pix_w(BITS)-1:0]   pix_data0,
  input  logic [pix_w(BITS)-1:0]   pix_data1,
  output logic [2:0]               rgb0,
  output logic [2:0]               rgb1,
  output logic [ADDR_W-1:0]        row_addr,
  output logic                     lat,
  output logic                     oe,
  output logic                     pclk,
  output logic                     frame_start,
  output logic                     busy
);

  localparam int COL_W = col_w(COLS);
  localparam int PIX_W = pix_w(BITS);
  localparam int PL_W  = col_w(BITS);
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int LC_W  = col_w(LAT_CYCLES);

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row;
  logic [PL_W-1:0]   plane;
  logic [LC_W-1:0]   lc;
  logic [7:0]        bright_q;
  logic [2:0]        smp0;
  logic [2:0]        smp1;
  logic              disp_start;
  logic              disp_done;

  logic plane_last, row_last, col_last, ph_last;

  assign pix_row    = row;
  assign pix_col    = col;
  assign plane_last = (plane == PL_W'(BITS - 1));
  assign row_last   = &row;
  assign col_last   = (col == COL_W'(COLS - 1));
  assign ph_last    = (ph == PH_W'(2 * CLK_DIV - 1));
  assign disp_start = (state == ST_LATCH) && (lc == LC_W'(LAT_CYCLES - 1));

  // Pick bit `plane` of each channel from the returned top/bottom pixels
  always_comb begin
    smp0 = '0;
    smp1 = '0;
    for (int c = CH_R; c <= CH_B; c++) begin
      smp0[c] = |((pix_data0 >> (c * BITS + int'(plane))) & PIX_W'(1));
      smp1[c] = |((pix_data1 >> (c * BITS + int'(plane))) & PIX_W'(1));
    end
  end

  hub75_bcm_oe #(
    .BITS       (BITS),
    .BASE_TICKS (BASE_TICKS)
  ) u_oe (
    .clk    (clk),
    .rst    (rst),
    .start  (disp_start),
    .plane  (plane),
    .bright (bright_q),
    .oe     (oe),
    .done   (disp_done)
  );

  // Scan sequencer; every pin is set on the edge that enters its cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ph          <= '0;
      col         <= '0;
      row         <= '0;
      plane       <= '0;
      lc          <= '0;
      bright_q    <= '0;
      rgb0        <= '0;
      rgb1        <= '0;
      row_addr    <= '0;
      lat         <= 1'b0;
      pclk        <= 1'b1;
      pix_rd      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      pix_rd      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            frame_start <= 1'b1;
            bright_q    <= bright;
            row         <= '0;
            plane       <= '0;
            busy        <= 1'b1;
            state       <= ST_SHIFT;
            ph          <= '0;
            col         <= '0;
            pclk        <= 1'b0;
            pix_rd      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ph_last) begin
            ph <= '0;
            if (col_last) begin
              state    <= ST_LATCH;
              pclk     <= 1'b1;
              lat      <= 1'b1;
              lc       <= '0;
              row_addr <= row;
            end else begin
              col    <= col + COL_W'(1);
              pclk   <= 1'b0;
              pix_rd <= 1'b1;
            end
          end else begin
            ph <= ph + PH_W'(1);
            if (ph == PH_W'(CLK_DIV - 1)) pclk <= 1'b1;
            // Read data is valid during phase 1; present it from phase 2
            if (ph == PH_W'(1)) begin
              rgb0 <= smp0;
              rgb1 <= smp1;
            end
          end
        end
        ST_LATCH: begin
          if (disp_start) begin
            lat   <= 1'b0;
            state <= ST_DISPLAY;
          end else begin
            lc <= lc + LC_W'(1);
          end
        end
        ST_DISPLAY: begin
          if (disp_done) begin
            if (plane_last) begin
              plane <= '0;
              if (row_last) begin
                row <= '0;
                if (en) begin
                  frame_start <= 1'b1;
                  bright_q    <= bright;
                end
              end else begin
                row <= row + ADDR_W'(1);
              end
            end else begin
              plane <= plane + PL_W'(1);
            end
            if (plane_last && row_last && !en) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= ST_SHIFT;
              ph     <= '0;
              col    <= '0;
              pclk   <= 1'b0;
              pix_rd <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
